nibble_shift_accumulator: RTL and testbench

- Sits directly downstream of the weight-nibble zero mux.
- Consumes the nibble-serial partial products (activation × one weight nibble, already forced to zero for all-zero nibbles) least-significant nibble first.
- Shifts each partial product into place and sums the nibbles into a full product, then adds that product to a running dot-product sum.
- Presents each updated sum on a valid/ready output, together with a per-product count of skipped (zero) nibbles for the approximation statistics.

---
 rtl/nibble_shift_accumulator.sv | 122 ++++++++++++
 tb/tb_nibble_shift_accumulator.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_shift_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : nibble_shift_accumulator
// Brief    : Shifts and sums nibble-serial partial products into a full product
//            and adds it to a running dot-product sum. Also counts zero nibbles.
// Revision : 1.0 - initial release
// ============================================================================
module nibble_shift_accumulator #(
    parameter int LOG2_WIDTH        = 4,
    parameter int WIDTH             = 2**LOG2_WIDTH,
    parameter int LOG2_NIBBLE_WIDTH = 2,
    parameter int NIBBLE_WIDTH      = 2**LOG2_NIBBLE_WIDTH,
    parameter int NUM_NIBBLES       = WIDTH/NIBBLE_WIDTH,
    parameter int ACC_GUARD         = 8,
    parameter int ACC_WIDTH         = 2*WIDTH+ACC_GUARD
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   pp_valid,
    output logic                                   pp_ready,
    input  logic [2*WIDTH-1:0]                     pp_data,
    input  logic                                   pp_nibble_zero,
    input  logic                                   pp_last,
    input  logic                                   acc_clear,
    output logic                                   res_valid,
    input  logic                                   res_ready,
    output logic [ACC_WIDTH-1:0]                   res_data,
    output logic [LOG2_WIDTH-LOG2_NIBBLE_WIDTH:0]  res_zero_cnt,
    output logic                                   err_nz
);

    localparam int IDX_W = LOG2_WIDTH - LOG2_NIBBLE_WIDTH;

    localparam logic [IDX_W-1:0] c_idx_zero = '0;
    localparam logic [IDX_W-1:0] c_idx_one  = IDX_W'(1);
    localparam logic [IDX_W-1:0] c_idx_max  = IDX_W'(NUM_NIBBLES - 1);

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t                 r_state;
    logic [IDX_W-1:0]       r_idx;
    logic [ACC_WIDTH-1:0]   r_prod;
    logic [ACC_WIDTH-1:0]   r_base;
    logic [ACC_WIDTH-1:0]   r_run;
    logic [IDX_W:0]         r_zcnt;
    logic [IDX_W:0]         r_res_zcnt;
    logic                   r_err_nz;

    logic                   w_accept;
    logic                   w_first;
    logic                   w_done;
    logic [LOG2_WIDTH-1:0]  w_shamt;
    logic [ACC_WIDTH-1:0]   w_term;
    logic [ACC_WIDTH-1:0]   w_prod;
    logic [ACC_WIDTH-1:0]   w_base;
    logic [IDX_W:0]         w_zcnt;
    logic [IDX_W:0]         w_zinc;

    assign pp_ready     = (r_state == ST_ACCUM);
    assign res_valid    = (r_state == ST_HOLD);
    assign res_data     = r_run;
    assign res_zero_cnt = r_res_zcnt;
    assign err_nz       = r_err_nz;

    assign w_accept = pp_valid && pp_ready;
    assign w_first  = (r_idx == c_idx_zero);
    assign w_done   = pp_last || (r_idx == c_idx_max);

    // Nibble position idx maps to a shift of idx*NIBBLE_WIDTH bits.
    assign w_shamt = {r_idx, {LOG2_NIBBLE_WIDTH{1'b0}}};
    assign w_term  = {{ACC_GUARD{1'b0}}, pp_data} << w_shamt;
    assign w_zinc  = {{IDX_W{1'b0}}, pp_nibble_zero};

    assign w_prod  = w_first ? w_term : (r_prod + w_term);
    assign w_zcnt  = w_first ? w_zinc : (r_zcnt + w_zinc);
    assign w_base  = w_first ? (acc_clear ? '0 : r_run) : r_base;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_ACCUM;
            r_idx      <= '0;
            r_prod     <= '0;
            r_base     <= '0;
            r_run      <= '0;
            r_zcnt     <= '0;
            r_res_zcnt <= '0;
            r_err_nz   <= 1'b0;
        end else begin
            case (r_state)
                ST_ACCUM: begin
                    if (w_accept) begin
                        r_prod <= w_prod;
                        r_zcnt <= w_zcnt;
                        r_base <= w_base;
                        if (pp_nibble_zero && (pp_data != '0)) begin
                            r_err_nz <= 1'b1;
                        end
                        if (w_done) begin
                            r_run      <= w_base + w_prod;
                            r_res_zcnt <= w_zcnt;
                            r_idx      <= '0;
                            r_state    <= ST_HOLD;
                        end else begin
                            r_idx <= r_idx + c_idx_one;
                        end
                    end
                end
                ST_HOLD: begin
                    if (res_ready) begin
                        r_state <= ST_ACCUM;
                    end
                end
                default: r_state <= ST_ACCUM;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nibble_shift_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_nibble_shift_accumulator
// Brief    : Directed self-checking bench with a reference model and result queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nibble_shift_accumulator;

    logic        clk;
    logic        rst_n;
    logic        pp_valid;
    logic        pp_ready;
    logic [31:0] pp_data;
    logic        pp_nibble_zero;
    logic        pp_last;
    logic        acc_clear;
    logic        res_valid;
    logic        res_ready;
    logic [39:0] res_data;
    logic [2:0]  res_zero_cnt;
    logic        err_nz;

    nibble_shift_accumulator dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pp_valid       (pp_valid),
        .pp_ready       (pp_ready),
        .pp_data        (pp_data),
        .pp_nibble_zero (pp_nibble_zero),
        .pp_last        (pp_last),
        .acc_clear      (acc_clear),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_data       (res_data),
        .res_zero_cnt   (res_zero_cnt),
        .err_nz         (err_nz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [39:0] d;
        logic [2:0]  z;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    int          m_idx  = 0;
    logic [39:0] m_prod = '0;
    logic [39:0] m_base = '0;
    logic [39:0] m_run  = '0;
    logic [2:0]  m_zc   = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offers one beat starting at a negedge; returns at the negedge after acceptance.
    task automatic beat(input logic [31:0] d, input logic z, input logic l, input logic c);
        int   t;
        bit   done;
        logic [39:0] term;
        pp_valid = 1'b1; pp_data = d; pp_nibble_zero = z; pp_last = l; acc_clear = c;
        t = 0; done = 0;
        while (!done && t < 20) begin
            if (pp_ready) begin
                @(posedge clk);
                done = 1;
            end else begin
                @(negedge clk);
                t++;
            end
        end
        if (!done) begin
            n_checks++; n_fail++;
            $display("FAIL beat_timeout: pp_ready never rose for data %0h", d);
        end else begin
            if (m_idx == 0) begin
                m_prod = '0;
                m_zc   = '0;
                m_base = c ? 40'h0 : m_run;
            end
            term   = {8'h00, d} << (4 * m_idx);
            m_prod = m_prod + term;
            m_zc   = m_zc + {2'b00, z};
            if (l || m_idx == 3) begin
                exp_t e;
                m_run = m_base + m_prod;
                e.d = m_run; e.z = m_zc;
                sb.push_back(e);
                m_idx = 0;
            end else begin
                m_idx++;
            end
        end
        @(negedge clk);
        pp_valid = 1'b0;
    endtask

    // Checks the held result against the model and the documented value, then takes it.
    task automatic take(input string tag, input logic [39:0] spec_d, input logic [2:0] spec_z);
        exp_t e;
        chk({tag, "_valid"}, 64'(res_valid), 64'd1);
        if (sb.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL %s_sb: observed empty queue expected one entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_model"}, 64'(res_data), 64'(e.d));
            chk({tag, "_zmodel"}, 64'(res_zero_cnt), 64'(e.z));
        end
        chk({tag, "_data"}, 64'(res_data), 64'(spec_d));
        chk({tag, "_zcnt"}, 64'(res_zero_cnt), 64'(spec_z));
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        chk({tag, "_ready_back"}, 64'(pp_ready), 64'd1);
    endtask

    task automatic case1(input logic c);
        beat(32'h03FC, 1'b0, 1'b0, c);
        beat(32'h02FD, 1'b0, 1'b0, 1'b0);
        beat(32'h01FE, 1'b0, 1'b0, 1'b0);
        beat(32'h00FF, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic case2(input logic c);
        beat(32'h0000, 1'b1, 1'b0, c);
        beat(32'h02FD, 1'b0, 1'b0, 1'b1);
        beat(32'h0000, 1'b1, 1'b0, 1'b1);
        beat(32'h00FF, 1'b0, 1'b1, 1'b1);
    endtask

    initial begin
        logic [39:0] held;
        rst_n = 1'b0; pp_valid = 1'b0; pp_data = '0; pp_nibble_zero = 1'b0;
        pp_last = 1'b0; acc_clear = 1'b0; res_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_pp_ready", 64'(pp_ready), 64'd1);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_res_data", 64'(res_data), 64'd0);
        chk("rst_zcnt", 64'(res_zero_cnt), 64'd0);
        chk("rst_err_nz", 64'(err_nz), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        case1(1'b1);
        take("full", 40'h1221CC, 3'd0);

        case2(1'b1);
        chk("zero_err_nz", 64'(err_nz), 64'd0);
        take("zeros", 40'h101FD0, 3'd2);

        case1(1'b1);
        take("acc_a", 40'h1221CC, 3'd0);
        case2(1'b0);
        take("acc_b", 40'h22419C, 3'd2);
        case1(1'b1);

        // Result left unclaimed for three cycles while the next beat is offered.
        held = res_data;
        pp_valid = 1'b1; pp_data = 32'h0050; pp_nibble_zero = 1'b0; pp_last = 1'b0; acc_clear = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("bp_pp_ready", 64'(pp_ready), 64'd0);
            chk("bp_res_valid", 64'(res_valid), 64'd1);
            chk("bp_data_stable", 64'(res_data), 64'(held));
            @(negedge clk);
        end
        chk("bp_ready_hold_cycle", 64'(pp_ready), 64'd0);
        take("acc_c", 40'h1221CC, 3'd0);
        chk("bp_res_valid_drop", 64'(res_valid), 64'd0);
        chk("bp_data_kept", 64'(res_data), 64'(held));

        beat(32'h0050, 1'b0, 1'b0, 1'b1);
        beat(32'h0020, 1'b0, 1'b1, 1'b0);
        take("early_last", 40'h000250, 3'd0);
        beat(32'h0007, 1'b0, 1'b1, 1'b1);
        take("single_beat", 40'h000007, 3'd0);

        beat(32'h0001, 1'b0, 1'b0, 1'b1);
        beat(32'h0001, 1'b0, 1'b0, 1'b0);
        beat(32'h0001, 1'b0, 1'b0, 1'b0);
        beat(32'h0001, 1'b0, 1'b0, 1'b0);
        take("forced", 40'h001111, 3'd0);

        chk("err_before", 64'(err_nz), 64'd0);
        beat(32'h0001, 1'b1, 1'b1, 1'b1);
        chk("err_set", 64'(err_nz), 64'd1);
        take("err_prod", 40'h000001, 3'd1);
        case2(1'b1);
        take("err_next", 40'h101FD0, 3'd2);
        chk("err_sticky", 64'(err_nz), 64'd1);

        beat(32'h03FC, 1'b0, 1'b0, 1'b1);
        beat(32'h02FD, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(res_valid), 64'd0);
        chk("mid_rst_err", 64'(err_nz), 64'd0);
        chk("mid_rst_data", 64'(res_data), 64'd0);
        chk("mid_rst_ready", 64'(pp_ready), 64'd1);
        m_idx = 0; m_run = '0; m_prod = '0; m_base = '0; m_zc = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        case1(1'b0);
        take("after_rst", 40'h1221CC, 3'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
